eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb.sv | 156 +++++++++++++++
 tb/tb_eth_tx_arb.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Two-port frame-granular arbiter in front of a 10G MAC TX stream.
// A grant holds from the first beat until the tlast handshake; ties alternate between ports.
module eth_tx_arb #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst,

  input  logic                 s0_tvalid,
  input  logic [63:0]          s0_tdata,
  input  logic [7:0]           s0_tkeep,
  input  logic                 s0_tlast,
  input  logic                 s0_tuser,
  output logic                 s0_tready,

  input  logic                 s1_tvalid,
  input  logic [63:0]          s1_tdata,
  input  logic [7:0]           s1_tkeep,
  input  logic                 s1_tlast,
  input  logic                 s1_tuser,
  output logic                 s1_tready,

  output logic                 eth_tx_tvalid,
  output logic [63:0]          eth_tx_tdata,
  output logic [7:0]           eth_tx_tkeep,
  output logic                 eth_tx_tlast,
  output logic                 eth_tx_tuser,
  input  logic                 eth_tx_tready,

  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_cnt0,
  output logic [CNT_WIDTH-1:0] frame_cnt1,
  output logic [1:0]           underrun
);

  typedef enum logic [1:0] {
    StIdle,
    StSend0,
    StSend1
  } state_e;

  state_e               state_q, state_d;
  logic                 last_served_q, last_served_d;
  logic [CNT_WIDTH-1:0] frame_cnt0_q, frame_cnt0_d;
  logic [CNT_WIDTH-1:0] frame_cnt1_q, frame_cnt1_d;
  logic [1:0]           underrun_q, underrun_d;
  logic                 first_beat_q, first_beat_d;
  logic                 accept;

  // Output mux: the granted port is passed straight through, everything else is zero.
  always_comb begin
    eth_tx_tvalid = 1'b0;
    eth_tx_tdata  = '0;
    eth_tx_tkeep  = '0;
    eth_tx_tlast  = 1'b0;
    eth_tx_tuser  = 1'b0;
    s0_tready     = 1'b0;
    s1_tready     = 1'b0;
    case (state_q)
      StSend0: begin
        eth_tx_tvalid = s0_tvalid;
        eth_tx_tdata  = s0_tdata;
        eth_tx_tkeep  = s0_tkeep;
        eth_tx_tlast  = s0_tlast;
        eth_tx_tuser  = s0_tuser;
        s0_tready     = eth_tx_tready;
      end
      StSend1: begin
        eth_tx_tvalid = s1_tvalid;
        eth_tx_tdata  = s1_tdata;
        eth_tx_tkeep  = s1_tkeep;
        eth_tx_tlast  = s1_tlast;
        eth_tx_tuser  = s1_tuser;
        s1_tready     = eth_tx_tready;
      end
      default: ;
    endcase
  end

  assign accept = eth_tx_tvalid & eth_tx_tready;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    frame_cnt0_d  = frame_cnt0_q;
    frame_cnt1_d  = frame_cnt1_q;
    underrun_d    = underrun_q;
    first_beat_d  = first_beat_q;
    case (state_q)
      StIdle: begin
        // On a tie the port that did not send the previous frame wins.
        if (s0_tvalid && s1_tvalid) begin
          state_d = last_served_q ? StSend0 : StSend1;
        end else if (s0_tvalid) begin
          state_d = StSend0;
        end else if (s1_tvalid) begin
          state_d = StSend1;
        end
        if (s0_tvalid || s1_tvalid) begin
          first_beat_d = 1'b1;
        end
      end
      StSend0: begin
        if (!first_beat_q && !s0_tvalid) begin
          underrun_d[0] = 1'b1;
        end
        if (accept) begin
          first_beat_d = 1'b0;
          if (s0_tlast) begin
            state_d       = StIdle;
            last_served_d = 1'b0;
            frame_cnt0_d  = frame_cnt0_q + CNT_WIDTH'(1);
          end
        end
      end
      StSend1: begin
        if (!first_beat_q && !s1_tvalid) begin
          underrun_d[1] = 1'b1;
        end
        if (accept) begin
          first_beat_d = 1'b0;
          if (s1_tlast) begin
            state_d       = StIdle;
            last_served_d = 1'b1;
            frame_cnt1_d  = frame_cnt1_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      frame_cnt0_q  <= '0;
      frame_cnt1_q  <= '0;
      underrun_q    <= 2'b00;
      first_beat_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      frame_cnt0_q  <= frame_cnt0_d;
      frame_cnt1_q  <= frame_cnt1_d;
      underrun_q    <= underrun_d;
      first_beat_q  <= first_beat_d;
    end
  end

  assign busy       = (state_q == StSend0) || (state_q == StSend1);
  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: directed scenarios plus a randomized run against a frame-level model.
module tb_eth_tx_arb;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic          clk156 = 1'b0;
  logic          sys_rst;
  logic          s0_tvalid, s0_tlast, s0_tuser, s0_tready;
  logic [63:0]   s0_tdata;
  logic [7:0]    s0_tkeep;
  logic          s1_tvalid, s1_tlast, s1_tuser, s1_tready;
  logic [63:0]   s1_tdata;
  logic [7:0]    s1_tkeep;
  logic          eth_tx_tvalid, eth_tx_tlast, eth_tx_tuser, eth_tx_tready;
  logic [63:0]   eth_tx_tdata;
  logic [7:0]    eth_tx_tkeep;
  logic          busy;
  logic [CW-1:0] frame_cnt0, frame_cnt1;
  logic [1:0]    underrun;

  eth_tx_arb #(.CNT_WIDTH(CW)) dut (
    .clk156        (clk156),
    .sys_rst       (sys_rst),
    .s0_tvalid     (s0_tvalid),
    .s0_tdata      (s0_tdata),
    .s0_tkeep      (s0_tkeep),
    .s0_tlast      (s0_tlast),
    .s0_tuser      (s0_tuser),
    .s0_tready     (s0_tready),
    .s1_tvalid     (s1_tvalid),
    .s1_tdata      (s1_tdata),
    .s1_tkeep      (s1_tkeep),
    .s1_tlast      (s1_tlast),
    .s1_tuser      (s1_tuser),
    .s1_tready     (s1_tready),
    .eth_tx_tvalid (eth_tx_tvalid),
    .eth_tx_tdata  (eth_tx_tdata),
    .eth_tx_tkeep  (eth_tx_tkeep),
    .eth_tx_tlast  (eth_tx_tlast),
    .eth_tx_tuser  (eth_tx_tuser),
    .eth_tx_tready (eth_tx_tready),
    .busy          (busy),
    .frame_cnt0    (frame_cnt0),
    .frame_cnt1    (frame_cnt1),
    .underrun      (underrun)
  );

  always #5 clk156 = ~clk156;

  int errors = 0;
  int checks = 0;

  beat_t q0[$], q1[$], exp0[$], exp1[$], log_b[$];
  int    log_src[$], log_cyc[$];
  int    cyc, pop0, pop1, gap_at0, gap_left0, rdy_mode;
  int unsigned vprob0, vprob1;
  logic  acc0, acc1;

  logic          sn_busy, sn_r0, sn_r1, sn_tvalid;
  beat_t         sn_beat;
  logic [CW-1:0] sn_cnt0, sn_cnt1;
  logic [1:0]    sn_und;

  // Present the head of each source queue (or junk with tvalid low) and the sink ready.
  task automatic drive();
    beat_t b0, b1;
    logic  v0, v1;
    v0 = (q0.size() > 0) && ($urandom_range(99) < vprob0);
    if (q0.size() > 0 && pop0 == gap_at0 && gap_left0 > 0) begin
      v0 = 1'b0;
      gap_left0--;
    end
    v1 = (q1.size() > 0) && ($urandom_range(99) < vprob1);
    if (v0) b0 = q0[0];
    else b0 = {$urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom)};
    if (v1) b1 = q1[0];
    else b1 = {$urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom)};
    s0_tvalid = v0;
    s0_tdata  = b0.data;
    s0_tkeep  = b0.keep;
    s0_tlast  = b0.last;
    s0_tuser  = b0.user;
    s1_tvalid = v1;
    s1_tdata  = b1.data;
    s1_tkeep  = b1.keep;
    s1_tlast  = b1.last;
    s1_tuser  = b1.user;
    case (rdy_mode)
      0:       eth_tx_tready = 1'b1;
      1:       eth_tx_tready = (cyc % 3 == 0);
      default: eth_tx_tready = ($urandom_range(99) < 70);
    endcase
  endtask

  task automatic sample_half();
    @(negedge clk156);
    sn_busy   = busy;
    sn_r0     = s0_tready;
    sn_r1     = s1_tready;
    sn_tvalid = eth_tx_tvalid;
    sn_beat   = {eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser};
    sn_cnt0   = frame_cnt0;
    sn_cnt1   = frame_cnt1;
    sn_und    = underrun;
    acc0      = !sys_rst && s0_tvalid && s0_tready;
    acc1      = !sys_rst && s1_tvalid && s1_tready;
    if (eth_tx_tvalid && eth_tx_tready) begin
      log_b.push_back(sn_beat);
      log_src.push_back(s0_tready ? 0 : (s1_tready ? 1 : -1));
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic advance_half();
    beat_t b;
    @(posedge clk156);
    #1;
    cyc++;
    if (acc0) begin b = q0.pop_front(); pop0++; end
    if (acc1) begin b = q1.pop_front(); pop1++; end
    drive();
  endtask

  task automatic clk_step();
    sample_half();
    advance_half();
  endtask

  task automatic run_until_log(input int n, input int bound);
    for (int k = 0; k < bound && log_b.size() < n; k++) clk_step();
    repeat (2) clk_step();
  endtask

  task automatic push_frame(input int port, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = {$urandom, $urandom, 8'($urandom), (i == len - 1), 1'($urandom)};
      if (port == 0) begin q0.push_back(b); exp0.push_back(b); end
      else begin q1.push_back(b); exp1.push_back(b); end
    end
  endtask

  task automatic clear_logs();
    log_b.delete();
    log_src.delete();
    log_cyc.delete();
    exp0.delete();
    exp1.delete();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    clear_logs();
    pop0 = 0; pop1 = 0; vprob0 = 100; vprob1 = 100; rdy_mode = 0;
    gap_at0 = -1; gap_left0 = 0; cyc = 0;
    sys_rst = 1'b1;
    drive();
    repeat (2) @(posedge clk156);
    #1;
    sys_rst = 1'b0;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset();
    do_reset();
    push_frame(0, 2);
    push_frame(1, 2);
    sys_rst = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      sample_half();
      checks++;
      if ({sn_busy, sn_tvalid, sn_r0, sn_r1, sn_beat, sn_cnt0, sn_cnt1, sn_und} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: busy=%b tvalid=%b rdy=%b%b beat=%h cnt=%0d/%0d und=%b, need all 0",
                 sn_busy, sn_tvalid, sn_r0, sn_r1, sn_beat, sn_cnt0, sn_cnt1, sn_und);
      end
      advance_half();
    end
    sys_rst = 1'b0;
    clk_step();
    sample_half();
    checks++;
    if (!(sn_busy && sn_r0 && !sn_r1 && sn_beat === exp0[0])) begin
      errors++;
      $display("FAIL reset_first_grant: busy=%b r0=%b r1=%b beat=%h, need port0 beat %h",
               sn_busy, sn_r0, sn_r1, sn_beat, exp0[0]);
    end
    advance_half();
  endtask

  task automatic test_single_port();
    int bad_r0;
    bad_r0 = 0;
    do_reset();
    push_frame(1, 3);
    drive();
    for (int k = 0; k < 8; k++) begin
      sample_half();
      if (sn_r0 !== 1'b0) bad_r0++;
      if (k == 0) begin
        checks++;
        if ({sn_busy, sn_tvalid, sn_r1} !== 3'b000) begin
          errors++;
          $display("FAIL single_bubble: busy/tvalid/r1=%b, need 000", {sn_busy, sn_tvalid, sn_r1});
        end
      end
      advance_half();
    end
    checks++;
    if (log_b.size() !== 3) begin
      errors++;
      $display("FAIL single_count: got %0d beats, need 3", log_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_b[i] !== exp1[i] || log_src[i] !== 1 || log_cyc[i] !== i + 1) begin
          errors++;
          $display("FAIL single_beat%0d: %h src%0d cyc%0d, need %h src1 cyc%0d",
                   i, log_b[i], log_src[i], log_cyc[i], exp1[i], i + 1);
        end
      end
    end
    checks++;
    if (sn_cnt1 !== CW'(1) || bad_r0 != 0) begin
      errors++;
      $display("FAIL single_cnt: frame_cnt1=%0d s0_tready_hits=%0d, need 1 and 0", sn_cnt1, bad_r0);
    end
  endtask

  task automatic test_alternate();
    beat_t e;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      push_frame(0, 2);
      push_frame(1, 2);
    end
    drive();
    run_until_log(16, 200);
    checks++;
    if (log_b.size() !== 16) begin
      errors++;
      $display("FAIL alt_count: got %0d beats, need 16", log_b.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        int f, port, gap;
        f    = i / 4;
        port = (i / 2) % 2;
        e    = (port == 0) ? exp0[2 * f + i % 2] : exp1[2 * f + i % 2];
        gap  = (i == 0) ? 0 : ((i % 2 == 0) ? 2 : 1);
        checks++;
        if (log_b[i] !== e || log_src[i] !== port ||
            (i > 0 && log_cyc[i] - log_cyc[i - 1] !== gap)) begin
          errors++;
          $display("FAIL alt_beat%0d: %h src%0d cyc%0d, need %h src%0d spacing %0d",
                   i, log_b[i], log_src[i], log_cyc[i], e, port, gap);
        end
      end
    end
    checks++;
    if (sn_cnt0 !== CW'(4) || sn_cnt1 !== CW'(4)) begin
      errors++;
      $display("FAIL alt_cnt: cnt0=%0d cnt1=%0d, need 4 and 4", sn_cnt0, sn_cnt1);
    end
  endtask

  task automatic test_stall();
    int bad_r1, bad_hold;
    bad_r1 = 0;
    bad_hold = 0;
    do_reset();
    push_frame(0, 5);
    push_frame(1, 2);
    rdy_mode = 1;
    drive();
    for (int k = 0; k < 200 && log_b.size() < 7; k++) begin
      sample_half();
      if (pop0 < 5 && sn_r1 !== 1'b0) bad_r1++;
      if (pop0 < 5 && sn_busy && sn_beat !== q0[0]) bad_hold++;
      advance_half();
    end
    checks++;
    if (bad_r1 != 0 || bad_hold != 0) begin
      errors++;
      $display("FAIL stall_hold: s1_tready_hits=%0d hold_errors=%0d, need 0 and 0", bad_r1, bad_hold);
    end
    checks++;
    if (log_b.size() !== 7) begin
      errors++;
      $display("FAIL stall_count: got %0d beats, need 7", log_b.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (log_b[i] !== ((i < 5) ? exp0[i] : exp1[i - 5]) || log_src[i] !== ((i < 5) ? 0 : 1)) begin
          errors++;
          $display("FAIL stall_beat%0d: %h src%0d, need %h src%0d", i, log_b[i], log_src[i],
                   (i < 5) ? exp0[i] : exp1[i - 5], (i < 5) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int bad_pre;
    bad_pre = 0;
    do_reset();
    push_frame(0, 4);
    gap_at0 = 2;
    gap_left0 = 2;
    drive();
    for (int k = 0; k < 100 && log_b.size() < 4; k++) begin
      sample_half();
      if (pop0 < 2 && sn_und !== 2'b00) bad_pre++;
      advance_half();
    end
    repeat (2) clk_step();
    checks++;
    if (bad_pre != 0 || sn_und !== 2'b01 || sn_cnt0 !== CW'(1) || log_b.size() !== 4) begin
      errors++;
      $display("FAIL underrun_set: early=%0d und=%b cnt0=%0d beats=%0d, need 0 01 1 4",
               bad_pre, sn_und, sn_cnt0, log_b.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_b[i] !== exp0[i]) begin
          errors++;
          $display("FAIL underrun_beat%0d: %h, need %h", i, log_b[i], exp0[i]);
        end
      end
    end
    clear_logs();
    push_frame(0, 2);
    drive();
    run_until_log(2, 50);
    checks++;
    if (sn_und !== 2'b01 || sn_cnt0 !== CW'(2)) begin
      errors++;
      $display("FAIL underrun_sticky: und=%b cnt0=%0d, need 01 and 2", sn_und, sn_cnt0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_frame(1, 2);
    drive();
    run_until_log(2, 50);
    checks++;
    if (sn_cnt1 !== CW'(1)) begin
      errors++;
      $display("FAIL midrst_pre: cnt1=%0d, need 1", sn_cnt1);
    end
    clear_logs();
    pop1 = 0;
    push_frame(1, 6);
    drive();
    for (int k = 0; k < 50 && pop1 < 2; k++) clk_step();
    sys_rst = 1'b1;
    clk_step();
    sys_rst = 1'b0;
    q1.delete();
    drive();
    sample_half();
    checks++;
    if (sn_busy !== 1'b0 || sn_tvalid !== 1'b0 || sn_cnt1 !== '0 || sn_r1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b tvalid=%b cnt1=%0d r1=%b, need 0 0 0 0",
               sn_busy, sn_tvalid, sn_cnt1, sn_r1);
    end
    advance_half();
    clear_logs();
    push_frame(0, 1);
    push_frame(1, 1);
    drive();
    run_until_log(2, 50);
    checks++;
    if (log_b.size() !== 2 || log_b[0] !== exp0[0] || log_src[0] !== 0 ||
        log_b[1] !== exp1[0] || log_src[1] !== 1) begin
      errors++;
      $display("FAIL midrst_rearb: beats=%0d, need s0 frame then s1 frame", log_b.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int f = 0; f < 16; f++) push_frame(0, 1);
    drive();
    run_until_log(16, 200);
    checks++;
    if (log_b.size() !== 16 || sn_cnt0 !== '0) begin
      errors++;
      $display("FAIL wrap16: beats=%0d cnt0=%0d, need 16 and 0", log_b.size(), sn_cnt0);
    end
    push_frame(0, 1);
    drive();
    run_until_log(17, 50);
    checks++;
    if (log_b.size() !== 17 || sn_cnt0 !== CW'(1)) begin
      errors++;
      $display("FAIL wrap17: beats=%0d cnt0=%0d, need 17 and 1", log_b.size(), sn_cnt0);
    end
  endtask

  // Frame-level reference: whoever owns the link forwards until its tlast handshake.
  task automatic test_random();
    int    owner, last, cnt[2], k;
    logic  first, v, l, e_tv, e_r0, e_r1;
    logic [1:0] und;
    beat_t e_beat;
    do_reset();
    owner = -1; last = 1; first = 1'b0; cnt[0] = 0; cnt[1] = 0; und = 2'b00;
    vprob0 = $urandom_range(100, 60);
    vprob1 = $urandom_range(100, 60);
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) begin
      push_frame(0, $urandom_range(5, 1));
      push_frame(1, $urandom_range(5, 1));
    end
    drive();
    for (k = 0; k < 4000; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && owner < 0) break;
      e_tv = 1'b0; e_beat = '0; e_r0 = 1'b0; e_r1 = 1'b0;
      if (owner == 0) begin
        e_tv = s0_tvalid; e_beat = {s0_tdata, s0_tkeep, s0_tlast, s0_tuser}; e_r0 = eth_tx_tready;
      end else if (owner == 1) begin
        e_tv = s1_tvalid; e_beat = {s1_tdata, s1_tkeep, s1_tlast, s1_tuser}; e_r1 = eth_tx_tready;
      end
      sample_half();
      checks++;
      if ({sn_tvalid, sn_beat} !== {e_tv, e_beat}) begin
        errors++;
        $display("FAIL rand_fwd cyc%0d: %b %h, need %b %h", cyc, sn_tvalid, sn_beat, e_tv, e_beat);
      end
      checks++;
      if ({sn_busy, sn_r0, sn_r1} !== {(owner >= 0), e_r0, e_r1}) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d: busy/r0/r1=%b, need %b", cyc, {sn_busy, sn_r0, sn_r1},
                 {(owner >= 0), e_r0, e_r1});
      end
      checks++;
      if (sn_cnt0 !== CW'(cnt[0]) || sn_cnt1 !== CW'(cnt[1]) || sn_und !== und) begin
        errors++;
        $display("FAIL rand_stat cyc%0d: cnt=%0d/%0d und=%b, need %0d/%0d %b",
                 cyc, sn_cnt0, sn_cnt1, sn_und, cnt[0], cnt[1], und);
      end
      if (owner < 0) begin
        if (s0_tvalid && s1_tvalid) owner = 1 - last;
        else if (s0_tvalid) owner = 0;
        else if (s1_tvalid) owner = 1;
        if (owner >= 0) first = 1'b1;
      end else begin
        v = (owner == 0) ? s0_tvalid : s1_tvalid;
        l = (owner == 0) ? s0_tlast : s1_tlast;
        if (!v && !first) und[owner] = 1'b1;
        if (v && eth_tx_tready) begin
          first = 1'b0;
          if (l) begin
            cnt[owner] = (cnt[owner] + 1) % (1 << CW);
            last = owner;
            owner = -1;
          end
        end
      end
      advance_half();
    end
    checks++;
    if (k >= 4000) begin
      errors++;
      $display("FAIL rand_timeout: %0d/%0d beats left after %0d cycles, need 0/0",
               q0.size(), q1.size(), k);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    eth_tx_tready = 1'b0;
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tuser = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
    test_reset();
    test_single_port();
    test_alternate();
    test_stall();
    test_underrun();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
